// File: rtl/clock_rate_loader.sv
// rtl/clock_rate_loader.sv - accepts a divider over valid/ready and serialises it onto the clock generator's mode/data config wires
module clock_rate_loader #(
  parameter int WIDTH         = 32,
  parameter int LEAD_CYCLES   = 1,
  parameter int GAP_CYCLES    = 4,
  parameter int MIN_COUNT     = 1,
  parameter int AUTOLOAD      = 1,
  parameter int DEFAULT_COUNT = 6000000
) (
  input  logic             fastClk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_count,
  output logic             cfg_ready,
  output logic             clock_change_mode,
  output logic             clock_max_count,
  output logic             busy,
  output logic [WIDTH-1:0] loaded_count,
  output logic             clamp_pulse
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LEAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam int MAX_A = (WIDTH > LEAD_CYCLES) ? WIDTH : LEAD_CYCLES;
  localparam int MAX_C = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);
  localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0]    LEAD_LAST  = CW'(LEAD_CYCLES - 1);
  localparam logic [CW-1:0]    WIDTH_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [WIDTH-1:0] MIN_C      = WIDTH'(MIN_COUNT);
  localparam logic [WIDTH-1:0] DEF_C      = WIDTH'(DEFAULT_COUNT);
  localparam logic             PRELOAD    = (AUTOLOAD != 0);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] frame_q, frame_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [WIDTH-1:0] loaded_q, loaded_d;
  logic             mode_q, mode_d;
  logic             data_q, data_d;
  logic             busy_q, busy_d;
  logic             clamp_q, clamp_d;
  logic             accept;

  assign cfg_ready         = !rst && !pend_full_q;
  assign accept            = cfg_valid && cfg_ready;
  assign clock_change_mode = mode_q;
  assign clock_max_count   = data_q;
  assign busy              = busy_q;
  assign loaded_count      = loaded_q;
  assign clamp_pulse       = clamp_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_d     = frame_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    loaded_d    = loaded_q;

    case (state_q)
      S_IDLE: begin
        if (pend_full_q) begin
          frame_d     = pend_q;
          pend_full_d = 1'b0;
          cnt_d       = '0;
          state_d     = (LEAD_CYCLES > 0) ? S_LEAD : S_SHIFT;
        end
      end
      S_LEAD: begin
        if (cnt_q == LEAD_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_q == WIDTH_LAST) begin
          state_d  = S_GAP;
          cnt_d    = '0;
          loaded_d = frame_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // accept only happens with pending empty, so it never collides with the IDLE drain
    if (accept) begin
      pend_d      = (cfg_count < MIN_C) ? MIN_C : cfg_count;
      pend_full_d = 1'b1;
    end

    clamp_d = accept && (cfg_count < MIN_C);
    mode_d  = (state_d == S_LEAD) || (state_d == S_SHIFT);
    data_d  = (state_d == S_SHIFT) && frame_d[cnt_d[IW-1:0]];
    busy_d  = (state_d != S_IDLE) || pend_full_d;
  end

  always_ff @(posedge fastClk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      frame_q     <= '0;
      pend_q      <= PRELOAD ? DEF_C : '0;
      pend_full_q <= PRELOAD;
      loaded_q    <= '0;
      mode_q      <= 1'b0;
      data_q      <= 1'b0;
      busy_q      <= 1'b0;
      clamp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      loaded_q    <= loaded_d;
      mode_q      <= mode_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      clamp_q     <= clamp_d;
    end
  end

endmodule

// File: tb/tb_clock_rate_loader.sv
// tb/tb_clock_rate_loader.sv - scoreboard bench: accepted dividers are queued and matched against frames rebuilt from the serial wires
module tb_clock_rate_loader;

  localparam int W    = 32;
  localparam int LEAD = 1;
  localparam int DEF  = 6000000;
  localparam int WIN  = LEAD + W;

  logic          fastClk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic [W-1:0]  cfg_count = '0;
  logic          cfg_ready;
  logic          clock_change_mode;
  logic          clock_max_count;
  logic          busy;
  logic [W-1:0]  loaded_count;
  logic          clamp_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  int           gap_q[$];

  bit           in_frame = 0;
  bit           lead_bad = 0;
  int           hi_cnt = 0;
  int           low_cnt = 0;
  logic [W-1:0] bits = '0;
  logic [W-1:0] exp_v;

  clock_rate_loader dut (
    .fastClk          (fastClk),
    .rst              (rst),
    .cfg_valid        (cfg_valid),
    .cfg_count        (cfg_count),
    .cfg_ready        (cfg_ready),
    .clock_change_mode(clock_change_mode),
    .clock_max_count  (clock_max_count),
    .busy             (busy),
    .loaded_count     (loaded_count),
    .clamp_pulse      (clamp_pulse)
  );

  always #5 fastClk = ~fastClk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Serial monitor: rebuild each mode-high window and match it against the scoreboard
  always @(negedge fastClk) begin
    if (rst) begin
      in_frame = 0;
      hi_cnt   = 0;
      low_cnt  = 0;
    end else if (clock_change_mode) begin
      if (!in_frame) begin
        in_frame = 1;
        hi_cnt   = 0;
        lead_bad = 0;
        bits     = '0;
        gap_q.push_back(low_cnt);
      end
      if (hi_cnt < LEAD) begin
        if (clock_max_count) lead_bad = 1;
      end else if (hi_cnt - LEAD < W) begin
        bits[hi_cnt-LEAD] = clock_max_count;
      end
      hi_cnt++;
    end else begin
      if (in_frame) begin
        check("window_len", hi_cnt, WIN);
        check("lead_zero", lead_bad, 0);
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          check("frame_value", bits, exp_v);
          check("loaded_count", loaded_count, exp_v);
        end
        in_frame = 0;
        low_cnt  = 0;
      end
      low_cnt++;
    end
  end

  task automatic send(input logic [W-1:0] v, output int stalls);
    bit ok;
    ok     = 0;
    stalls = 0;
    @(negedge fastClk);
    cfg_valid = 1'b1;
    cfg_count = v;
    while (!ok && stalls < 1000) begin
      ok = cfg_ready;
      @(posedge fastClk);
      if (!ok) begin
        stalls++;
        @(negedge fastClk);
      end
    end
    if (!ok) begin
      check("send_timeout", 0, 1);
    end else begin
      exp_q.push_back((v < 1) ? 1 : v);
      #1;
      check("clamp_pulse", clamp_pulse, (v < 1));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge fastClk);
    while (busy && n < 2000) begin
      @(negedge fastClk);
      n++;
    end
    if (n >= 2000) check("idle_timeout", 0, 1);
  endtask

  initial begin
    int s;
    logic [W-1:0] v;

    // Reset state and autoloaded default frame
    exp_q.push_back(DEF);
    repeat (2) @(negedge fastClk);
    check("rst_mode", clock_change_mode, 0);
    check("rst_data", clock_max_count, 0);
    check("rst_busy", busy, 0);
    check("rst_loaded", loaded_count, 0);
    check("rst_ready", cfg_ready, 0);
    check("rst_clamp", clamp_pulse, 0);
    rst = 1'b0;
    repeat (2) @(negedge fastClk);
    check("auto_busy", busy, 1);
    wait_idle();
    check("auto_loaded", loaded_count, DEF);
    check("auto_idle", busy, 0);
    check("auto_ready", cfg_ready, 1);

    // Single request: mode rises one edge after accept, bit 0 one edge later
    send(32'h0000_00A5, s);
    check("single_mode_n", clock_change_mode, 0);
    cfg_valid = 1'b0;
    @(posedge fastClk); #1;
    check("single_mode_n1", clock_change_mode, 1);
    check("single_lead", clock_max_count, 0);
    @(posedge fastClk); #1;
    check("single_bit0", clock_max_count, 1);
    wait_idle();
    check("single_loaded", loaded_count, 32'hA5);

    // Clamp of a zero request
    send(0, s);
    cfg_valid = 1'b0;
    @(posedge fastClk); #1;
    check("clamp_one_cycle", clamp_pulse, 0);
    wait_idle();
    check("clamp_loaded", loaded_count, 1);

    // Back-to-back with valid held high: 20 waits one cycle, 30 waits out 10's whole frame
    gap_q.delete();
    send(10, s);
    send(20, s);
    check("b2b_stall_20", s, 1);
    send(30, s);
    check("b2b_stall_30", s, 37);
    cfg_valid = 1'b0;
    wait_idle();
    check("b2b_sb_empty", exp_q.size(), 0);
    check("b2b_gap_count", gap_q.size(), 3);
    if (gap_q.size() == 3) begin
      check("b2b_gap_1", gap_q[1], 5);
      check("b2b_gap_2", gap_q[2], 5);
    end

    // Reset during SHIFT bit 12 (bit 12 of 0x12345678 is 1)
    send(32'h1234_5678, s);
    cfg_valid = 1'b0;
    repeat (14) @(posedge fastClk);
    #1;
    check("mid_mode_before", clock_change_mode, 1);
    check("mid_bit12", clock_max_count, 1);
    rst = 1'b1;
    #1;
    check("mid_mode_async", clock_change_mode, 0);
    check("mid_data_async", clock_max_count, 0);
    check("mid_loaded", loaded_count, 0);
    check("mid_ready", cfg_ready, 0);
    check("mid_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(negedge fastClk);
    exp_q.push_back(DEF);
    rst = 1'b0;
    #1;
    check("mid_ready_preload", cfg_ready, 0);
    repeat (2) @(negedge fastClk);
    wait_idle();
    check("mid_reload", loaded_count, DEF);
    check("mid_ready_after", cfg_ready, 1);

    // Randomised stream with idle gaps and occasional clamped zeros
    for (int i = 0; i < 200; i++) begin
      v = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      send(v, s);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge fastClk);
        cfg_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge fastClk);
      end
    end
    cfg_valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge fastClk);
    check("rand_sb_empty", exp_q.size(), 0);
    check("rand_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
